// File: rtl/bcp_clause_engine.sv
// bcp_clause_engine: scans a stored clause database one clause per cycle against the live
// assignment, streaming unit implications over valid/ready and aborting on the first conflict.
module bcp_clause_engine #(
    parameter int VAR_PER_CLAUSE = 5,
    parameter int NUM_VARIABLE = 128,
    parameter int NUM_CLAUSE = 1024,
    parameter int VAR_IDX_W = $clog2(NUM_VARIABLE),
    parameter int CLAUSE_IDX_W = $clog2(NUM_CLAUSE)
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      wr_en,
    input  logic [CLAUSE_IDX_W-1:0]                   wr_addr,
    input  logic [VAR_PER_CLAUSE-1:0][VAR_IDX_W-1:0]  wr_var,
    input  logic [VAR_PER_CLAUSE-1:0]                 wr_mask,
    input  logic [VAR_PER_CLAUSE-1:0]                 wr_pole,
    input  logic [NUM_VARIABLE-1:0]                   assigned,
    input  logic [NUM_VARIABLE-1:0]                   value,
    input  logic                                      start,
    input  logic [CLAUSE_IDX_W:0]                     num_clauses,
    output logic                                      busy,
    output logic                                      impl_valid,
    input  logic                                      impl_ready,
    output logic [VAR_IDX_W-1:0]                      impl_var,
    output logic                                      impl_value,
    output logic [CLAUSE_IDX_W-1:0]                   impl_clause,
    output logic                                      done,
    output logic                                      conflict,
    output logic [CLAUSE_IDX_W-1:0]                   conflict_clause,
    output logic                                      all_sat
);
    localparam int CNT_W = $clog2(VAR_PER_CLAUSE + 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t                                  state;
    logic [CLAUSE_IDX_W:0]                   ptr;
    logic                                    sat_acc;
    logic [VAR_PER_CLAUSE-1:0][VAR_IDX_W-1:0] db_var [NUM_CLAUSE];
    logic [VAR_PER_CLAUSE-1:0]               db_mask [NUM_CLAUSE];
    logic [VAR_PER_CLAUSE-1:0]               db_pole [NUM_CLAUSE];
    logic [CLAUSE_IDX_W-1:0]                 idx;
    logic                                    wr_ok;
    logic                                    any_true;
    logic [CNT_W-1:0]                        n_open;
    logic [VAR_IDX_W-1:0]                    open_var;
    logic                                    open_pole;
    logic                                    is_sat;
    logic                                    is_conf;
    logic                                    is_unit;
    logic                                    can_load;
    logic                                    last;

    assign idx      = ptr[CLAUSE_IDX_W-1:0];
    assign wr_ok    = wr_en && state == IDLE;
    assign busy     = state != IDLE;
    assign is_sat   = db_mask[idx] == '0 || any_true;
    assign is_conf  = !is_sat && n_open == '0;
    assign is_unit  = !is_sat && n_open == CNT_W'(1);
    assign can_load = !impl_valid || impl_ready;
    assign last     = ptr + (CLAUSE_IDX_W + 1)'(1) == num_clauses;

    always_ff @(posedge clock) begin
        if (wr_ok) begin
            db_var[wr_addr]  <= wr_var;
            db_pole[wr_addr] <= wr_pole;
        end
    end

    // Only the masks need clearing: an all-zero mask marks an empty slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CLAUSE; i++) db_mask[i] <= '0;
        end else if (wr_ok) begin
            db_mask[wr_addr] <= wr_mask;
        end
    end

    always_comb begin
        any_true  = 1'b0;
        n_open    = '0;
        open_var  = '0;
        open_pole = 1'b0;
        for (int j = 0; j < VAR_PER_CLAUSE; j++) begin
            if (db_mask[idx][j]) begin
                if (!assigned[db_var[idx][j]]) begin
                    n_open    = n_open + CNT_W'(1);
                    open_var  = db_var[idx][j];
                    open_pole = db_pole[idx][j];
                end else if (value[db_var[idx][j]] == db_pole[idx][j]) begin
                    any_true = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            ptr             <= '0;
            sat_acc         <= 1'b0;
            impl_valid      <= 1'b0;
            impl_var        <= '0;
            impl_value      <= 1'b0;
            impl_clause     <= '0;
            done            <= 1'b0;
            conflict        <= 1'b0;
            conflict_clause <= '0;
            all_sat         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (impl_valid && impl_ready) impl_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    ptr      <= '0;
                    conflict <= 1'b0;
                    all_sat  <= num_clauses == '0;
                    sat_acc  <= 1'b1;
                    done     <= num_clauses == '0;
                    state    <= num_clauses == '0 ? DONE : SCAN;
                end
                SCAN: if (is_conf) begin
                    conflict        <= 1'b1;
                    conflict_clause <= idx;
                    done            <= 1'b1;
                    state           <= DONE;
                end else if (!is_unit || can_load) begin
                    // A unit clause stalls the pointer until the output register frees up.
                    if (is_unit) begin
                        impl_valid  <= 1'b1;
                        impl_var    <= open_var;
                        impl_value  <= open_pole;
                        impl_clause <= idx;
                    end
                    if (!is_sat) sat_acc <= 1'b0;
                    ptr <= ptr + (CLAUSE_IDX_W + 1)'(1);
                    if (last) state <= DRAIN;
                end
                DRAIN: if (!impl_valid) begin
                    done    <= 1'b1;
                    all_sat <= sat_acc;
                    state   <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcp_clause_engine.sv
// tb_bcp_clause_engine: directed and random scans checked against a clause-level reference model.
module tb_bcp_clause_engine;
    localparam int VPC = 5;
    localparam int NV = 128;
    localparam int NC = 1024;
    localparam int VW = 7;
    localparam int CW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_en = 1'b0;
    logic [CW-1:0] wr_addr = '0;
    logic [VPC-1:0][VW-1:0] wr_var = '0;
    logic [VPC-1:0] wr_mask = '0;
    logic [VPC-1:0] wr_pole = '0;
    logic [NV-1:0] assigned = '0;
    logic [NV-1:0] value = '0;
    logic start = 1'b0;
    logic [CW:0] num_clauses = '0;
    logic impl_ready = 1'b0;
    logic busy, impl_valid, impl_value, done, conflict, all_sat;
    logic [VW-1:0] impl_var;
    logic [CW-1:0] impl_clause, conflict_clause;

    int total = 0;
    int bad = 0;

    int m_var[NC][VPC];
    bit [VPC-1:0] m_mask[NC];
    bit [VPC-1:0] m_pole[NC];
    logic [31:0] exp_q[$];

    bcp_clause_engine dut (
        .clock(clk), .reset(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_var(wr_var),
        .wr_mask(wr_mask), .wr_pole(wr_pole), .assigned(assigned), .value(value),
        .start(start), .num_clauses(num_clauses), .busy(busy), .impl_valid(impl_valid),
        .impl_ready(impl_ready), .impl_var(impl_var), .impl_value(impl_value),
        .impl_clause(impl_clause), .done(done), .conflict(conflict),
        .conflict_clause(conflict_clause), .all_sat(all_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int c);
        wr_en = 1'b1;
        wr_addr = CW'(c);
        wr_mask = m_mask[c];
        wr_pole = m_pole[c];
        for (int j = 0; j < VPC; j++) wr_var[j] = VW'(m_var[c][j]);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic set_clause(input int c, input bit [VPC-1:0] mask, input bit [VPC-1:0] pole,
                              input int v0, input int v1, input int v2, input int v3, input int v4);
        m_mask[c] = mask;
        m_pole[c] = pole;
        m_var[c][0] = v0; m_var[c][1] = v1; m_var[c][2] = v2; m_var[c][3] = v3; m_var[c][4] = v4;
        wr(c);
    endtask

    // kind: 0 satisfied, 1 unresolved, 2 unit, 3 conflict
    task automatic classify(input int c, output int kind, output int iv, output bit ip);
        int nt = 0;
        int no = 0;
        iv = 0;
        ip = 1'b0;
        for (int j = 0; j < VPC; j++) begin
            if (m_mask[c][j]) begin
                if (!assigned[m_var[c][j]]) begin
                    no++;
                    iv = m_var[c][j];
                    ip = m_pole[c][j];
                end else if (value[m_var[c][j]] == m_pole[c][j]) nt++;
            end
        end
        kind = (m_mask[c] == 0 || nt > 0) ? 0 : no == 0 ? 3 : no == 1 ? 2 : 1;
    endtask

    task automatic run_scan(input int n, input int rdy_pct, input int low_cyc,
                            input int exp_done, input bit wr_try);
        int kind, iv, cyc, dcyc;
        bit ip, econf, esat, seen, hold;
        int ecc;
        logic [31:0] prev;
        econf = 1'b0; esat = 1'b1; ecc = 0;
        exp_q.delete();
        for (int c = 0; c < n; c++) begin
            classify(c, kind, iv, ip);
            if (kind != 0) esat = 1'b0;
            if (kind == 3) begin
                econf = 1'b1;
                ecc = c;
                break;
            end
            if (kind == 2) exp_q.push_back({14'd0, VW'(iv), ip, CW'(c)});
        end
        num_clauses = (CW + 1)'(n);
        start = 1'b1;
        impl_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; dcyc = -1; seen = 1'b0; hold = 1'b0; prev = '0;
        while (1) begin
            impl_ready = cyc > low_cyc && $urandom_range(99) < rdy_pct;
            if (wr_try) begin
                wr_en = cyc == 3;
                wr_addr = CW'(10);
                wr_mask = '1;
                for (int j = 0; j < VPC; j++) wr_var[j] = VW'(127);
                wr_pole = {VPC{~value[127]}};
            end
            if (hold) begin
                check("impl_hold_valid", {31'd0, impl_valid}, 32'd1);
                check("impl_hold_data", {14'd0, impl_var, impl_value, impl_clause}, prev);
            end
            if (impl_valid && impl_ready) begin
                if (exp_q.size() == 0) check("impl_extra", 32'd1, 32'd0);
                else check("impl_data", {14'd0, impl_var, impl_value, impl_clause}, exp_q.pop_front());
            end
            hold = impl_valid && !impl_ready;
            prev = {14'd0, impl_var, impl_value, impl_clause};
            if (seen && cyc == dcyc + 1) check("done_pulse_width", {31'd0, done}, 32'd0);
            if (done && !seen) begin
                seen = 1'b1;
                dcyc = cyc;
                check("conflict", {31'd0, conflict}, {31'd0, econf});
                check("all_sat", {31'd0, all_sat}, {31'd0, esat});
                if (econf) check("conflict_clause", {22'd0, conflict_clause}, ecc);
            end
            if (seen && !impl_valid && !busy) break;
            if (cyc > 4 * n + 100) begin
                check("scan_timeout", 32'd1, 32'd0);
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        wr_en = 1'b0;
        impl_ready = 1'b0;
        check("impl_remaining", exp_q.size(), 32'd0);
        if (exp_done >= 0) check("done_cycle", dcyc, exp_done);
    endtask

    initial begin
        for (int c = 0; c < NC; c++) m_mask[c] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_impl_valid", {31'd0, impl_valid}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_conflict", {31'd0, conflict}, 0);
        check("rst_all_sat", {31'd0, all_sat}, 0);
        check("rst_impl", {14'd0, impl_var, impl_value, impl_clause}, 0);
        check("rst_conflict_clause", {22'd0, conflict_clause}, 0);
        rst = 1'b0;

        // (x1 | ~x2 | x3) with x2=1, x3=0: unit on x1=1
        assigned[2] = 1'b1; value[2] = 1'b1;
        assigned[3] = 1'b1; value[3] = 1'b0;
        set_clause(0, 5'b00111, 5'b00101, 1, 2, 3, 0, 0);
        run_scan(1, 100, 0, 4, 1'b0);

        // x1=0 too: conflict on clause 0
        assigned[1] = 1'b1; value[1] = 1'b0;
        run_scan(3, 100, 0, 2, 1'b0);

        // four unit clauses with back-pressure for 5 cycles
        for (int c = 0; c < 4; c++) set_clause(c, 5'b00001, 5'b00001, 10 + c, 0, 0, 0, 0);
        run_scan(4, 100, 5, 11, 1'b0);

        // 16 satisfied clauses; a write attempted mid-scan must be dropped
        for (int v = 20; v < 36; v++) begin assigned[v] = 1'b1; value[v] = 1'b1; end
        assigned[127] = 1'b1; value[127] = 1'b0;
        for (int c = 0; c < 16; c++) set_clause(c, 5'b00011, 5'b00001, 20 + c, 50, 0, 0, 0);
        run_scan(16, 100, 0, 18, 1'b1);
        run_scan(16, 100, 0, 18, 1'b0);

        // empty scan
        run_scan(0, 100, 0, 1, 1'b0);

        // reset during a stall clears everything including the database
        for (int c = 0; c < 4; c++) set_clause(c, 5'b00001, 5'b00001, 10 + c, 0, 0, 0, 0);
        num_clauses = 11'd4;
        start = 1'b1;
        impl_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("stall_busy", {31'd0, busy}, 1);
        check("stall_impl_valid", {31'd0, impl_valid}, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_impl_valid", {31'd0, impl_valid}, 0);
        check("midrst_impl", {14'd0, impl_var, impl_value, impl_clause}, 0);
        check("midrst_done", {31'd0, done}, 0);
        for (int c = 0; c < NC; c++) m_mask[c] = '0;
        run_scan(8, 100, 0, 10, 1'b0);

        // random clause sets and assignments over a small variable pool
        for (int it = 0; it < 14; it++) begin
            int n;
            n = $urandom_range(40, 1);
            for (int v = 0; v < 16; v++) begin
                assigned[v] = $urandom_range(3) != 0;
                value[v] = $urandom_range(1) == 1;
            end
            for (int c = 0; c < n; c++)
                set_clause(c, $urandom_range(9) == 0 ? 5'b0 : VPC'($urandom_range(31)),
                           VPC'($urandom_range(31)), $urandom_range(15), $urandom_range(15),
                           $urandom_range(15), $urandom_range(15), $urandom_range(15));
            run_scan(n, 60, 0, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
